// File: rtl/pipeline_pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pc_sequencer_if
//  Description : Bundles the datapath-facing signals of the PC sequencer.
//                The master side is the pipeline datapath; the slave side
//                is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_pc_sequencer_if;

    // Datapath -> sequencer
    logic [31:0] pc_current;
    logic        load_use_hazard;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        eret_valid;
    logic        md_start;
    logic        md_done;

    // Sequencer -> datapath
    logic        pc_enable;
    logic [31:0] pc_next;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        exl;
    logic [31:0] stall_count;

    modport master (
        output pc_current, load_use_hazard, branch_taken, branch_target,
               jump_valid, jump_target, exc_req, exc_cause, exc_pc,
               eret_valid, md_start, md_done,
        input  pc_enable, pc_next, stall_if_id, flush_if_id, flush_id_ex,
               epc, cause, exl, stall_count
    );

    modport slave (
        input  pc_current, load_use_hazard, branch_taken, branch_target,
               jump_valid, jump_target, exc_req, exc_cause, exc_pc,
               eret_valid, md_start, md_done,
        output pc_enable, pc_next, stall_if_id, flush_if_id, flush_id_ex,
               epc, cause, exl, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pc_sequencer
//  Description : Next-PC selection, pipeline stall/flush control, and a
//                minimal exception state (EPC/cause/EXL) for a 5-stage core.
//                Handles multi-cycle mult/div waits and a one-cycle drain
//                after trap entry.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    pipeline_pc_sequencer_if.slave       bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_WAIT   = 2'd1,
        EXC_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q;
    logic [4:0]  cause_q;
    logic        exl_q;
    logic [31:0] stall_count_q;

    logic        w_pc_enable;
    logic [31:0] w_pc_next;
    logic        w_stall_if_id;
    logic        w_flush_if_id;
    logic        w_flush_id_ex;
    logic [31:0] w_pc_plus4;
    logic        w_exc_accept;
    logic        w_do_eret;

    assign w_pc_plus4 = bus.pc_current + 32'd4;

    // A trap is only taken while no handler is active; a nested request
    // falls through to the lower-priority selections.
    assign w_exc_accept = (state_q == RUN) && bus.exc_req && !exl_q;
    assign w_do_eret    = (state_q == RUN) && !w_exc_accept && bus.eret_valid;

    // Next-state and per-cycle PC/stall/flush selection.
    always_comb begin
        state_d       = state_q;
        w_pc_enable   = 1'b1;
        w_pc_next     = w_pc_plus4;
        w_stall_if_id = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;

        if (reset) begin
            state_d   = RUN;
            w_pc_next = RESET_PC;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_exc_accept) begin
                        w_pc_next     = EXC_VECTOR;
                        w_flush_if_id = 1'b1;
                        w_flush_id_ex = 1'b1;
                        state_d       = EXC_DRAIN;
                    end else if (bus.eret_valid) begin
                        w_pc_next     = epc_q;
                        w_flush_if_id = 1'b1;
                    end else if (bus.md_start) begin
                        // md_start wins over a simultaneous md_done: the
                        // result belongs to the operation issued now.
                        w_pc_enable   = 1'b0;
                        w_stall_if_id = 1'b1;
                        w_flush_id_ex = 1'b1;
                        state_d       = MD_WAIT;
                    end else if (bus.load_use_hazard) begin
                        w_pc_enable   = 1'b0;
                        w_stall_if_id = 1'b1;
                        w_flush_id_ex = 1'b1;
                    end else if (bus.jump_valid) begin
                        w_pc_next = bus.jump_target;
                    end else if (bus.branch_taken) begin
                        w_pc_next = bus.branch_target;
                    end
                end
                MD_WAIT: begin
                    // The op in ID/EX stays put while the unit works, so no
                    // bubble is injected here.
                    if (bus.md_done) begin
                        state_d = RUN;
                    end else begin
                        w_pc_enable   = 1'b0;
                        w_stall_if_id = 1'b1;
                    end
                end
                EXC_DRAIN: begin
                    // Discard the instruction fetched alongside trap entry.
                    w_flush_if_id = 1'b1;
                    state_d       = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, exception registers and stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            epc_q         <= 32'd0;
            cause_q       <= 5'd0;
            exl_q         <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (!w_pc_enable) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
            if (w_exc_accept) begin
                epc_q   <= bus.exc_pc;
                cause_q <= bus.exc_cause;
                exl_q   <= 1'b1;
            end else if (w_do_eret) begin
                exl_q <= 1'b0;
            end
        end
    end

    assign bus.pc_enable   = w_pc_enable;
    assign bus.pc_next     = w_pc_next;
    assign bus.stall_if_id = w_stall_if_id;
    assign bus.flush_if_id = w_flush_if_id;
    assign bus.flush_id_ex = w_flush_id_ex;
    assign bus.epc         = epc_q;
    assign bus.cause       = cause_q;
    assign bus.exl         = exl_q;
    assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire
